// File: rtl/mips_cpu_muldiv_ctrl.sv
// Issue/sequencing stage in front of the HI/LO unit: accepts MF*/MT*/MULT*/DIV* from decode,
// drives and holds the unit's opcode for the op's latency. Optional: MULDIV_DIV0_BYPASS_EN.
module mips_cpu_muldiv_ctrl #(
    parameter int MULT_LAT    = 3,
    parameter int DIV_MAX_CYC = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    output logic        req_ready,
    output logic        busy,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        err,
    output logic [5:0]  hl_opcode,
    output logic [31:0] hl_a,
    output logic [31:0] hl_b,
    output logic        hl_valid_in,
    input  logic        hl_valid_out,
    input  logic [31:0] hl_hi,
    input  logic [31:0] hl_lo
);

    // state      | meaning
    // S_IDLE     | ready for decode; MF* reads serviced here without leaving
    // S_XFER     | MTHI/MTLO presented to the HI/LO unit for one cycle
    // S_MUL_WAIT | MULT/MULTU opcode held until the product is in HI/LO
    // S_DIV_START| divide start pulse on hl_valid_in
    // S_DIV_WAIT | waiting for hl_valid_out, watchdog counting down
    // S_DIV_SETTLE| HI/LO unit commits the divide result
    typedef enum logic [2:0] {
        S_IDLE,
        S_XFER,
        S_MUL_WAIT,
        S_DIV_START,
        S_DIV_WAIT,
        S_DIV_SETTLE
    } state_t;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam int CNT_MAX = (MULT_LAT > DIV_MAX_CYC) ? MULT_LAT : DIV_MAX_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    logic is_mf;
    logic is_mt;
    logic is_mul;
    logic is_div;
    logic div_skip;

    assign is_mf  = (req_op == F_MFHI) || (req_op == F_MFLO);
    assign is_mt  = (req_op == F_MTHI) || (req_op == F_MTLO);
    assign is_mul = (req_op == F_MULT) || (req_op == F_MULTU);
    assign is_div = (req_op == F_DIV)  || (req_op == F_DIVU);

`ifdef MULDIV_DIV0_BYPASS_EN
    // Divide by zero is swallowed at issue so HI/LO keep their previous contents.
    assign div_skip = is_div && (req_rt == 32'd0);
`else
    assign div_skip = 1'b0;
`endif

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= 32'd0;
            err         <= 1'b0;
            hl_opcode   <= 6'd0;
            hl_a        <= 32'd0;
            hl_b        <= 32'd0;
            hl_valid_in <= 1'b0;
        end else begin
            rd_valid    <= 1'b0;
            err         <= 1'b0;
            hl_valid_in <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (is_mf) begin
                            rd_data  <= (req_op == F_MFHI) ? hl_hi : hl_lo;
                            rd_valid <= 1'b1;
                        end else if (is_mt) begin
                            state     <= S_XFER;
                            hl_opcode <= req_op;
                            hl_a      <= req_rs;
                            hl_b      <= req_rt;
                        end else if (is_mul) begin
                            state     <= S_MUL_WAIT;
                            hl_opcode <= req_op;
                            hl_a      <= req_rs;
                            hl_b      <= req_rt;
                            cnt       <= CNT_W'(MULT_LAT - 1);
                        end else if (is_div && !div_skip) begin
                            state       <= S_DIV_START;
                            hl_opcode   <= req_op;
                            hl_a        <= req_rs;
                            hl_b        <= req_rt;
                            hl_valid_in <= 1'b1;
                        end
                    end
                end
                S_XFER: begin
                    state     <= S_IDLE;
                    hl_opcode <= 6'd0;
                end
                S_MUL_WAIT: begin
                    if (cnt == '0) begin
                        state     <= S_IDLE;
                        hl_opcode <= 6'd0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DIV_START: begin
                    // hl_valid_out is deliberately not looked at here
                    state <= S_DIV_WAIT;
                    cnt   <= CNT_W'(DIV_MAX_CYC - 1);
                end
                S_DIV_WAIT: begin
                    if (hl_valid_out) begin
                        state <= S_DIV_SETTLE;
                    end else if (cnt == '0) begin
                        state     <= S_IDLE;
                        hl_opcode <= 6'd0;
                        err       <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DIV_SETTLE: begin
                    state     <= S_IDLE;
                    hl_opcode <= 6'd0;
                end
                default: begin
                    state     <= S_IDLE;
                    hl_opcode <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Bench for mips_cpu_muldiv_ctrl: behavioural HI/LO unit, per-cycle timeline model and
// directed ops with literal results.
module tb_mips_cpu_muldiv_ctrl;

    localparam int MULT_LAT    = 3;
    localparam int DIV_MAX_CYC = 40;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [5:0]  req_op;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic        req_ready;
    logic        busy;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        err;
    logic [5:0]  hl_opcode;
    logic [31:0] hl_a;
    logic [31:0] hl_b;
    logic        hl_valid_in;
    logic        hl_valid_out;
    logic [31:0] hl_hi;
    logic [31:0] hl_lo;

    mips_cpu_muldiv_ctrl #(.MULT_LAT(MULT_LAT), .DIV_MAX_CYC(DIV_MAX_CYC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
        .req_ready(req_ready), .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data),
        .err(err), .hl_opcode(hl_opcode), .hl_a(hl_a), .hl_b(hl_b),
        .hl_valid_in(hl_valid_in), .hl_valid_out(hl_valid_out),
        .hl_hi(hl_hi), .hl_lo(hl_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {hi, lo} an ideal HI/LO unit would hold after the op; x/0 gives hi=a, lo=all ones
    function automatic logic [63:0] calc(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        p = 64'd0;
        case (op)
            F_MULT:  p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            F_MULTU: p = {32'd0, a} * {32'd0, b};
            F_DIV, F_DIVU: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    if (op == F_DIV) begin
                        q = 32'($signed(a) / $signed(b));
                        r = 32'($signed(a) % $signed(b));
                    end else begin
                        q = a / b;
                        r = a % b;
                    end
                    p = {r, q};
                end
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    // Behavioural HI/LO unit
    int          div_lat = 3;
    bit          glitch_en = 1'b0;
    logic [31:0] u_hi;
    logic [31:0] u_lo;
    int          u_cnt;
    int          u_mcnt;
    bit          u_active;
    bit          u_done;
    logic [5:0]  u_dop;
    logic [31:0] u_da;
    logic [31:0] u_db;

    assign hl_hi = u_hi;
    assign hl_lo = u_lo;
    assign hl_valid_out = (u_active && u_cnt == 1) || (glitch_en && hl_valid_in);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_hi <= 32'd0; u_lo <= 32'd0; u_cnt <= 0; u_mcnt <= 0;
            u_active <= 1'b0; u_done <= 1'b0; u_dop <= 6'd0; u_da <= 32'd0; u_db <= 32'd0;
        end else begin
            if (hl_opcode == F_MTHI) u_hi <= hl_a;
            if (hl_opcode == F_MTLO) u_lo <= hl_a;
            if (hl_opcode == F_MULT || hl_opcode == F_MULTU) begin
                if (u_mcnt == MULT_LAT - 1) {u_hi, u_lo} <= calc(hl_opcode, hl_a, hl_b);
                u_mcnt <= u_mcnt + 1;
            end else begin
                u_mcnt <= 0;
            end
            if (hl_valid_in) begin
                u_active <= (div_lat > 0);
                u_cnt    <= div_lat;
                u_dop    <= hl_opcode;
                u_da     <= hl_a;
                u_db     <= hl_b;
            end else if (u_active) begin
                if (u_cnt == 1) begin
                    u_active <= 1'b0;
                    u_done   <= 1'b1;
                end else begin
                    u_cnt <= u_cnt - 1;
                end
            end
            if (u_done) begin
                u_done <= 1'b0;
                if (hl_opcode == u_dop) {u_hi, u_lo} <= calc(u_dop, u_da, u_db);
            end
        end
    end

    // Timeline model: each accepted op appends the outputs it must produce cycle by cycle
    typedef struct packed {
        logic       busy;
        logic [5:0] op;
        logic       vin;
        logic       err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    logic [31:0] m_rd_data = 32'd0;
    bit          rd_pend = 1'b0;

    task automatic model_accept(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt);
        logic [63:0] r;
        case (op)
            F_MFHI: begin rd_pend = 1'b1; m_rd_data = m_hi; end
            F_MFLO: begin rd_pend = 1'b1; m_rd_data = m_lo; end
            F_MTHI, F_MTLO: begin
                m_a = rs; m_b = rt;
                q.push_back('{1'b1, op, 1'b0, 1'b0});
                if (op == F_MTHI) m_hi = rs; else m_lo = rs;
            end
            F_MULT, F_MULTU: begin
                m_a = rs; m_b = rt;
                for (int i = 0; i < MULT_LAT; i++) q.push_back('{1'b1, op, 1'b0, 1'b0});
                r = calc(op, rs, rt);
                m_hi = r[63:32]; m_lo = r[31:0];
            end
            F_DIV, F_DIVU: begin
`ifdef MULDIV_DIV0_BYPASS_EN
                if (rt == 32'd0) return;
`endif
                m_a = rs; m_b = rt;
                q.push_back('{1'b1, op, 1'b1, 1'b0});
                if (div_lat >= 1 && div_lat <= DIV_MAX_CYC) begin
                    for (int i = 0; i < div_lat + 1; i++) q.push_back('{1'b1, op, 1'b0, 1'b0});
                    r = calc(op, rs, rt);
                    m_hi = r[63:32]; m_lo = r[31:0];
                end else begin
                    for (int i = 0; i < DIV_MAX_CYC; i++) q.push_back('{1'b1, op, 1'b0, 1'b0});
                    q.push_back('{1'b0, 6'd0, 1'b0, 1'b1});
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        exp_t cur;
        forever begin
            @(negedge clk);
            if (!reset) begin
                q.delete();
                rd_pend = 1'b0; m_rd_data = 32'd0;
                m_a = 32'd0; m_b = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
            end else begin
                cur = '{1'b0, 6'd0, 1'b0, 1'b0};
                if (q.size() > 0) cur = q.pop_front();
                check("busy", 32'(busy), 32'(cur.busy));
                check("req_ready", 32'(req_ready), 32'(!cur.busy));
                check("hl_opcode", 32'(hl_opcode), 32'(cur.op));
                check("hl_valid_in", 32'(hl_valid_in), 32'(cur.vin));
                check("err", 32'(err), 32'(cur.err));
                check("rd_valid", 32'(rd_valid), 32'(rd_pend));
                check("rd_data", rd_data, m_rd_data);
                check("hl_a", hl_a, m_a);
                check("hl_b", hl_b, m_b);
                rd_pend = 1'b0;
                if (req_valid && !cur.busy) model_accept(req_op, req_rs, req_rt);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt);
        req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        check("accept_wait", 32'(req_ready), 32'd1);
        sync();
        req_valid = 1'b0; req_op = 6'd0; req_rs = 32'd0; req_rt = 32'd0;
    endtask

    task automatic do_mf(input logic [5:0] op, input logic [31:0] exp, input string name);
        do_op(op, 32'd0, 32'd0);
        check({name, "_valid"}, 32'(rd_valid), 32'd1);
        check(name, rd_data, exp);
    endtask

    // Returns at the first negedge with busy low
    task automatic count_busy(output int n, output int vin);
        n = 0; vin = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (hl_valid_in) vin++;
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int v;
        reset = 1'b0; req_valid = 1'b0; req_op = 6'd0; req_rs = 32'd0; req_rt = 32'd0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_opcode", 32'(hl_opcode), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        sync();

        // MULTU 0xFFFFFFFF * 2
        do_op(F_MULTU, 32'hFFFF_FFFF, 32'd2);
        count_busy(n, v);
        check("t1_busy_cycles", 32'(n), 32'd3);
        sync();
        do_mf(F_MFHI, 32'd1, "t1_mfhi");
        do_mf(F_MFLO, 32'hFFFF_FFFE, "t1_mflo");

        // DIVU 100/7 with a spurious valid_out during DIV_START
        div_lat = 3; glitch_en = 1'b1;
        do_op(F_DIVU, 32'd100, 32'd7);
        count_busy(n, v);
        glitch_en = 1'b0;
        check("t2_valid_in_pulses", 32'(v), 32'd1);
        check("t2_busy_cycles", 32'(n), 32'd5);
        sync();
        do_mf(F_MFLO, 32'd14, "t2_mflo");
        do_mf(F_MFHI, 32'd2, "t2_mfhi");

        // MTHI then MFHI immediately, then back-to-back MFLO
        do_op(F_MTHI, 32'h1234_5678, 32'd0);
        do_mf(F_MFHI, 32'h1234_5678, "t3_mfhi");
        do_mf(F_MFLO, 32'd14, "t3_mflo_b2b");

        // Signed MULT -3*5, signed DIV -100/7 with shortest divide latency
        do_op(F_MULT, 32'hFFFF_FFFD, 32'd5);
        count_busy(n, v);
        sync();
        do_mf(F_MFHI, 32'hFFFF_FFFF, "mult_hi");
        do_mf(F_MFLO, 32'hFFFF_FFF1, "mult_lo");
        div_lat = 1;
        do_op(F_DIV, 32'hFFFF_FF9C, 32'd7);
        count_busy(n, v);
        check("div_fast_busy", 32'(n), 32'd3);
        sync();
        do_mf(F_MFLO, 32'hFFFF_FFF2, "div_lo");
        do_mf(F_MFHI, 32'hFFFF_FFFE, "div_hi");
        do_mf(F_MFHI, 32'hFFFF_FFFE, "div_hi_again");

        // Unlisted funct: accepted, nothing happens
        do_op(6'b100000, 32'd1, 32'd2);
        @(negedge clk);
        check("unlisted_busy", 32'(busy), 32'd0);
        sync();

        // Watchdog abort
        do_op(F_MTHI, 32'h1234_5678, 32'd0);
        div_lat = 0;
        do_op(F_DIVU, 32'd5, 32'd1);
        count_busy(n, v);
        check("t4_busy_cycles", 32'(n), 32'd41);
        check("t4_err", 32'(err), 32'd1);
        check("t4_ready", 32'(req_ready), 32'd1);
        check("t4_opcode", 32'(hl_opcode), 32'd0);
        @(negedge clk);
        check("t4_err_pulse", 32'(err), 32'd0);
        sync();
        do_mf(F_MFHI, 32'h1234_5678, "t4_hi_kept");

        // valid_out in the last watchdog cycle wins
        div_lat = DIV_MAX_CYC;
        do_op(F_DIVU, 32'd1000, 32'd10);
        count_busy(n, v);
        check("edge_busy_cycles", 32'(n), 32'd42);
        check("edge_no_err", 32'(err), 32'd0);
        sync();
        do_mf(F_MFLO, 32'd100, "edge_mflo");

        // Divide by zero
        div_lat = 3;
        do_op(F_DIVU, 32'd55, 32'd0);
        count_busy(n, v);
`ifdef MULDIV_DIV0_BYPASS_EN
        check("t6_busy_cycles", 32'(n), 32'd0);
        check("t6_valid_in", 32'(v), 32'd0);
        sync();
        do_mf(F_MFHI, 32'd0, "t6_mfhi");
        do_mf(F_MFLO, 32'd100, "t6_mflo");
`else
        check("t6_busy_cycles", 32'(n), 32'd5);
        check("t6_err", 32'(err), 32'd0);
        sync();
        do_mf(F_MFHI, 32'd55, "t6_mfhi");
        do_mf(F_MFLO, 32'hFFFF_FFFF, "t6_mflo");
`endif

        // Reset in DIV_WAIT, then MTLO/MFLO
        div_lat = 0;
        do_op(F_DIVU, 32'd9, 32'd3);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(req_ready), 32'd1);
        check("t5_opcode", 32'(hl_opcode), 32'd0);
        check("t5_valid_in", 32'(hl_valid_in), 32'd0);
        check("t5_err", 32'(err), 32'd0);
        check("t5_rd_valid", 32'(rd_valid), 32'd0);
        check("t5_rd_data", rd_data, 32'd0);
        check("t5_hl_a", hl_a, 32'd0);
        check("t5_hl_b", hl_b, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        sync();
        do_op(F_MTLO, 32'hA5A5_A5A5, 32'd0);
        do_mf(F_MFLO, 32'hA5A5_A5A5, "t5_mflo");
        repeat (3) sync();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
